// File: rtl/sc_switch_input.sv
// ----------------------------------------------------------------------------
// sc_switch_input
// Front end for the board's slide switches and pushbuttons. Every raw input is
// synchronized into the clock domain and then debounced. A change is accepted
// only after it has stayed steady for DEB_CYCLES consecutive synchronized
// cycles. The clean values are presented as three 32-bit words for a CPU
// input port, plus a one-cycle press pulse per key.
//
// Ports
//   clock     in   1   sole clock, rising edge
//   reset     in   1   asynchronous, active-high reset
//   sw        in  10   raw slide switches, active-high
//   key       in   4   raw pushbuttons, active-low (0 = pressed)
//   key_clr   in   4   per-key clear of the sticky event bits
//   in_port0  out 32   {27'b0, debounced sw[4:0]}
//   in_port1  out 32   {27'b0, debounced sw[9:5]}
//   in_port2  out 32   {24'b0, key_event[3:0], key_down[3:0]}
//   key_press out  4   one-cycle pulse per key on each debounced press
// ----------------------------------------------------------------------------
module sc_switch_input #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  input  logic [3:0]  key_clr,
  output logic [31:0] in_port0,
  output logic [31:0] in_port1,
  output logic [31:0] in_port2,
  output logic [3:0]  key_press
);

  // The counter qualifies a change when it reaches this value. It then clears,
  // so it never counts past it and never wraps.
  localparam logic [19:0] CNT_MAX = 20'(DEB_CYCLES - 1);

  // Switch group: sync chain, shared counter, stable value, output registers
  logic [9:0]  r_swS1, r_swS2, r_swS3, r_swStable;
  logic [19:0] r_swCnt;
  logic [4:0]  r_inPort0, r_inPort1;
  logic        w_swIncr;

  // Key group: each bit has its own counter and stable bit
  logic [3:0]  r_keyS1, r_keyS2, r_keyS3, r_keyStable, r_keyStablePrev;
  logic [19:0] r_keyCnt [4];
  logic [3:0]  r_keyDown, r_keyEvent, r_keyPress;
  logic [3:0]  w_keyIncr;
  logic [3:0]  w_pressNext;

  // Counting continues only while the synchronized value is steady and also
  // differs from the accepted value. Any movement, or agreement with the
  // accepted value, restarts qualification.
  assign w_swIncr  = (r_swS2 != r_swStable) && (r_swS2 == r_swS3);
  assign w_keyIncr = (r_keyS2 ^ r_keyStable) & ~(r_keyS2 ^ r_keyS3);

  // A press is a debounced 1->0 transition of the active-low key.
  assign w_pressNext = r_keyStablePrev & ~r_keyStable;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_swS1     <= '0;
      r_swS2     <= '0;
      r_swS3     <= '0;
      r_swStable <= '0;
      r_swCnt    <= '0;
      r_inPort0  <= '0;
      r_inPort1  <= '0;
    end else begin
      r_swS1 <= sw;
      r_swS2 <= r_swS1;
      r_swS3 <= r_swS2;
      if (!w_swIncr) begin
        r_swCnt <= '0;
      end else if (r_swCnt == CNT_MAX) begin
        r_swCnt    <= '0;
        r_swStable <= r_swS2;
      end else begin
        r_swCnt <= r_swCnt + 20'd1;
      end
      r_inPort0 <= r_swStable[4:0];
      r_inPort1 <= r_swStable[9:5];
    end
  end

  // Keys reset to the released level (all ones), so no press is seen when
  // reset is released with the buttons up.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_keyS1         <= 4'b1111;
      r_keyS2         <= 4'b1111;
      r_keyS3         <= 4'b1111;
      r_keyStable     <= 4'b1111;
      r_keyStablePrev <= 4'b1111;
      for (int i = 0; i < 4; i++) begin
        r_keyCnt[i] <= '0;
      end
    end else begin
      r_keyS1         <= key;
      r_keyS2         <= r_keyS1;
      r_keyS3         <= r_keyS2;
      r_keyStablePrev <= r_keyStable;
      for (int i = 0; i < 4; i++) begin
        if (!w_keyIncr[i]) begin
          r_keyCnt[i] <= '0;
        end else if (r_keyCnt[i] == CNT_MAX) begin
          r_keyCnt[i]    <= '0;
          r_keyStable[i] <= r_keyS2[i];
        end else begin
          r_keyCnt[i] <= r_keyCnt[i] + 20'd1;
        end
      end
    end
  end

  // The event bit is sticky. A press that is being generated on this edge
  // overrides a clear on the same edge, so software cannot lose a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_keyDown  <= '0;
      r_keyEvent <= '0;
      r_keyPress <= '0;
    end else begin
      r_keyDown  <= ~r_keyStable;
      r_keyPress <= w_pressNext;
      r_keyEvent <= w_pressNext | (r_keyEvent & ~key_clr);
    end
  end

  assign in_port0  = {27'b0, r_inPort0};
  assign in_port1  = {27'b0, r_inPort1};
  assign in_port2  = {24'b0, r_keyEvent, r_keyDown};
  assign key_press = r_keyPress;

endmodule

// File: tb/tb_sc_switch_input.sv
// ----------------------------------------------------------------------------
// tb_sc_switch_input
// Directed self-checking bench for sc_switch_input with DEB_CYCLES = 4.
// With this setting, a change sampled at edge e0 appears on the outputs after
// edge e0+7. Inputs are driven and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_sc_switch_input;

  logic        clock;
  logic        reset;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [3:0]  key_clr;
  logic [31:0] in_port0, in_port1, in_port2;
  logic [3:0]  key_press;

  int testCount;
  int failCount;

  sc_switch_input #(.DEB_CYCLES(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .sw       (sw),
    .key      (key),
    .key_clr  (key_clr),
    .in_port0 (in_port0),
    .in_port1 (in_port1),
    .in_port2 (in_port2),
    .key_press(key_press)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance past one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    sw      = '0;
    key     = 4'b1111;
    key_clr = '0;
    tick();
    tick();
    testCount++;
    if ({in_port0, in_port1, in_port2, key_press} !== 100'd0) begin
      failCount++;
      $display("[TB] FAIL reset_state: got p0=%h p1=%h p2=%h kp=%b expected all zero",
               in_port0, in_port1, in_port2, key_press);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      testCount++;
      if ({in_port0, in_port1, in_port2, key_press} !== 100'd0) begin
        failCount++;
        $display("[TB] FAIL idle_after_reset cycle %0d: got p0=%h p1=%h p2=%h kp=%b expected all zero",
                 i, in_port0, in_port1, in_port2, key_press);
      end
    end
  endtask

  task automatic test_sw_qualify(input logic [9:0] val, input logic [31:0] exp0,
                                 input logic [31:0] exp1, input logic [31:0] old0,
                                 input logic [31:0] old1);
    sw = val;
    for (int i = 0; i < 7; i++) tick();
    testCount++;
    if (in_port0 !== old0 || in_port1 !== old1) begin
      failCount++;
      $display("[TB] FAIL sw_early_%h: got p0=%h p1=%h expected p0=%h p1=%h",
               val, in_port0, in_port1, old0, old1);
    end
    tick();
    testCount++;
    if (in_port0 !== exp0 || in_port1 !== exp1) begin
      failCount++;
      $display("[TB] FAIL sw_latency_%h: got p0=%h p1=%h expected p0=%h p1=%h",
               val, in_port0, in_port1, exp0, exp1);
    end
  endtask

  task automatic test_sw_glitch();
    sw = 10'h001;
    for (int i = 0; i < 3; i++) tick();
    sw = 10'h000;
    for (int i = 0; i < 12; i++) begin
      tick();
      testCount++;
      if (in_port0 !== 32'h0) begin
        failCount++;
        $display("[TB] FAIL sw_glitch cycle %0d: got p0=%h expected 00000000", i, in_port0);
      end
    end
  endtask

  task automatic test_key_press();
    key = 4'b1011;
    for (int i = 0; i < 7; i++) begin
      tick();
      testCount++;
      if (key_press !== 4'b0000 || in_port2 !== 32'h0) begin
        failCount++;
        $display("[TB] FAIL key_press_early cycle %0d: got kp=%b p2=%h expected kp=0000 p2=00000000",
                 i, key_press, in_port2);
      end
    end
    tick();
    testCount++;
    if (key_press !== 4'b0100 || in_port2 !== 32'h44) begin
      failCount++;
      $display("[TB] FAIL key_press_pulse: got kp=%b p2=%h expected kp=0100 p2=00000044",
               key_press, in_port2);
    end
    tick();
    testCount++;
    if (key_press !== 4'b0000 || in_port2 !== 32'h44) begin
      failCount++;
      $display("[TB] FAIL key_press_single: got kp=%b p2=%h expected kp=0000 p2=00000044",
               key_press, in_port2);
    end
    key = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      testCount++;
      if (key_press !== 4'b0000) begin
        failCount++;
        $display("[TB] FAIL key_release_pulse cycle %0d: got kp=%b expected 0000", i, key_press);
      end
    end
    testCount++;
    if (in_port2 !== 32'h40) begin
      failCount++;
      $display("[TB] FAIL key_release_status: got p2=%h expected 00000040", in_port2);
    end
  endtask

  task automatic test_key_clear();
    key_clr = 4'b0100;
    tick();
    key_clr = 4'b0000;
    testCount++;
    if (in_port2 !== 32'h00) begin
      failCount++;
      $display("[TB] FAIL key_clear_event2: got p2=%h expected 00000000", in_port2);
    end
    key_clr = 4'b1000;
    tick();
    key_clr = 4'b0000;
    testCount++;
    if (in_port2 !== 32'h00) begin
      failCount++;
      $display("[TB] FAIL key_clear_idle_bit: got p2=%h expected 00000000", in_port2);
    end
    // Press key 1 with a clear landing on the same edge as the press pulse.
    key = 4'b1101;
    for (int i = 0; i < 7; i++) tick();
    key_clr = 4'b0010;
    tick();
    key_clr = 4'b0000;
    testCount++;
    if (key_press !== 4'b0010 || in_port2 !== 32'h22) begin
      failCount++;
      $display("[TB] FAIL key_set_wins: got kp=%b p2=%h expected kp=0010 p2=00000022",
               key_press, in_port2);
    end
    tick();
    testCount++;
    if (key_press !== 4'b0000 || in_port2 !== 32'h22) begin
      failCount++;
      $display("[TB] FAIL key_event_hold: got kp=%b p2=%h expected kp=0000 p2=00000022",
               key_press, in_port2);
    end
    key = 4'b1111;
    for (int i = 0; i < 8; i++) tick();
    testCount++;
    if (in_port2 !== 32'h20) begin
      failCount++;
      $display("[TB] FAIL key1_release: got p2=%h expected 00000020", in_port2);
    end
    key_clr = 4'b0010;
    tick();
    key_clr = 4'b0000;
    testCount++;
    if (in_port2 !== 32'h00) begin
      failCount++;
      $display("[TB] FAIL key_clear_event1: got p2=%h expected 00000000", in_port2);
    end
  endtask

  task automatic test_key_simultaneous();
    key = 4'b0000;
    for (int i = 0; i < 7; i++) tick();
    testCount++;
    if (key_press !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL key_all_early: got kp=%b expected 0000", key_press);
    end
    tick();
    testCount++;
    if (key_press !== 4'b1111 || in_port2 !== 32'hFF) begin
      failCount++;
      $display("[TB] FAIL key_all_pulse: got kp=%b p2=%h expected kp=1111 p2=000000ff",
               key_press, in_port2);
    end
    key = 4'b1111;
    for (int i = 0; i < 8; i++) tick();
    testCount++;
    if (key_press !== 4'b0000 || in_port2 !== 32'hF0) begin
      failCount++;
      $display("[TB] FAIL key_all_release: got kp=%b p2=%h expected kp=0000 p2=000000f0",
               key_press, in_port2);
    end
  endtask

  task automatic test_reset_mid();
    sw = 10'h0AB;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    #1;
    testCount++;
    if ({in_port0, in_port1, in_port2, key_press} !== 100'd0) begin
      failCount++;
      $display("[TB] FAIL reset_async: got p0=%h p1=%h p2=%h kp=%b expected all zero",
               in_port0, in_port1, in_port2, key_press);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    testCount++;
    if (in_port0 !== 32'h0 || in_port1 !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL reset_restart_early: got p0=%h p1=%h expected 0 0", in_port0, in_port1);
    end
    tick();
    testCount++;
    if (in_port0 !== 32'h0B || in_port1 !== 32'h05) begin
      failCount++;
      $display("[TB] FAIL reset_restart_value: got p0=%h p1=%h expected p0=0000000b p1=00000005",
               in_port0, in_port1);
    end
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    test_reset();
    test_sw_qualify(10'h3E5, 32'h05, 32'h1F, 32'h0, 32'h0);
    test_sw_qualify(10'h000, 32'h00, 32'h00, 32'h05, 32'h1F);
    test_sw_glitch();
    test_sw_qualify(10'h21F, 32'h1F, 32'h10, 32'h0, 32'h0);
    test_key_press();
    test_key_clear();
    test_key_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
